tdm_slot_mux: RTL and testbench
===============================

// Module: tdm_slot_mux
// PURPOSE
//  Parametrised time-division slot scheduler and data multiplexer, successor to the fixed 4-channel splitter.
//  Cycles through NUM_CH source channels; each slot lasts a run-time programmable number of cycles.
//  Forwards the active channel's data when that channel is enabled; outputs zero otherwise.
//  Adds an optional skip of disabled channels, pause without loss of position, slot/frame strobes,
//  and a valid flag. Sits between the per-channel ROM sources and the downstream serialiser.
// PARAMETERS
//  NUM_CH   4  number of source channels (>=2)
//  DATA_W   8  data width per channel
//  CNT_W    8  slot counter width
//  SYM_DIV  13 modulus of the free-running symbol counter (>=2)
//  SKIP_DIS 0  1 = disabled channels get no slot; 0 = disabled channels keep their slot, output zero
//  Derived: CH_W = max(1,clog2(NUM_CH)); SYM_W = max(1,clog2(SYM_DIV))
// PORTS
//  clk          in   1               system clock, rising edge
//  rst          in   1               synchronous reset, active high
//  run          in   1               1 = advance schedule; 0 = pause
//  ch_en        in   NUM_CH          per-channel enable, bit i = channel i
//  slot_len     in   NUM_CH*CNT_W    per-channel terminal count, field i = [i*CNT_W +: CNT_W]; slot = slot_len+1 cycles
//  ch_data      in   NUM_CH*DATA_W   per-channel data, field i = [i*DATA_W +: DATA_W]
//  data_out     out  DATA_W          muxed data (registered)
//  data_valid   out  1               data_out carries enabled-channel data
//  chan         out  CH_W            active channel index
//  count        out  CNT_W           cycle count within the current slot
//  sym_cnt      out  SYM_W           free-running symbol counter, 0..SYM_DIV-1
//  slot_start   out  1               1-cycle pulse: first cycle of a new slot after a wrap
//  frame_start  out  1               1-cycle pulse: slot_start into channel 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): all outputs and internal state = 0. rst has priority over run. rst mid-slot aborts the slot.
//  - Pause (run=0, rst=0): chan, count, sym_cnt hold. data_out<=0, data_valid<=0, slot_start<=0, frame_start<=0.
//  - Run (run=1): terminal tc = (count >= slot_len[chan]). Live value used; >= makes a mid-slot reduction
//    below count end the slot on the next cycle.
//    - tc=0: count<=count+1.
//    - tc=1: count<=0; chan<=next(chan); slot_start<=1; frame_start<=(next(chan)==0). Otherwise both strobes <=0.
//  - next(c), SKIP_DIS=0: (c+1) mod NUM_CH.
//  - next(c), SKIP_DIS=1: first enabled channel in cyclic order c+1, c+2, ..., c.
//    If only c is enabled, returns c (back-to-back slots on c, strobes still pulse).
//    If no channel is enabled, falls back to (c+1) mod NUM_CH.
//  - Disabling the active channel mid-slot does not truncate the slot; the slot runs to tc with data_valid=0.
//  - Data path, 1-cycle latency, sampled with pre-update chan:
//    data_out<=ch_en[chan]?ch_data[chan]:0; data_valid<=run&ch_en[chan].
//  - sym_cnt: +1 per run cycle; SYM_DIV-1 -> 0. Independent of slot boundaries.
//  - No slot_start/frame_start pulses for the first slot after reset; first strobe comes at first wrap.
//  - slot_len=0 gives 1-cycle slots; consecutive slot_start pulses are legal.
//  - count never exceeds max(slot_len) seen since slot entry; no 2^CNT_W wrap in normal use.
// TESTING
//  1 Defaults, slot_len ch0..3={142,109,76,43}, ch_en=4'hF, run=1 after rst
//    -> ch0 143 cycles, ch1 110, ch2 77, ch3 44; frame_start every 374 cycles.
//  2 ch_en=4'b1101, SKIP_DIS=0 -> ch1 keeps its 110-cycle slot with data_out=0, data_valid=0.
//    SKIP_DIS=1 -> chan sequence 0,2,3,0; frame 264 cycles.
//  3 run=0 for 10 cycles at chan=1, count=50 -> count stays 50, sym_cnt frozen, data_valid=0;
//    after run=1, count=51 one cycle later.
//  4 rst pulse at chan=2, count=30 -> next cycle chan=0, count=0, sym_cnt=0, data_out=0, all strobes 0.
//  5 26 run cycles from reset -> sym_cnt 0..12,0..12; data_out tracks ch_data[chan] one cycle late (check at a slot edge).
//  6 At chan=0, count=100, slot_len[0] set to 20 -> next edge count=0, chan=1, slot_start=1.
//    SKIP_DIS=1, ch_en=4'b0000 -> chan still rotates 0,1,2,3.

Source files
------------

// File: rtl/tdm_slot_mux_if.sv
// rtl/tdm_slot_mux_if.sv - schedule controls in, muxed data and slot status out
interface tdm_slot_mux_if #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    parameter int SYM_DIV = 13
);
    localparam int CH_W  = (NUM_CH  > 2) ? $clog2(NUM_CH)  : 1;
    localparam int SYM_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;

    logic                       run;
    logic [NUM_CH-1:0]          ch_en;
    logic [NUM_CH*CNT_W-1:0]    slot_len;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic [DATA_W-1:0]          data_out;
    logic                       data_valid;
    logic [CH_W-1:0]            chan;
    logic [CNT_W-1:0]           count;
    logic [SYM_W-1:0]           sym_cnt;
    logic                       slot_start;
    logic                       frame_start;

    modport master (
        output run, ch_en, slot_len, ch_data,
        input  data_out, data_valid, chan, count, sym_cnt, slot_start, frame_start
    );

    modport slave (
        input  run, ch_en, slot_len, ch_data,
        output data_out, data_valid, chan, count, sym_cnt, slot_start, frame_start
    );
endinterface

// File: rtl/tdm_slot_mux.sv
// rtl/tdm_slot_mux.sv - time-division slot scheduler and per-channel data multiplexer
module tdm_slot_mux #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 8,
    parameter int SYM_DIV  = 13,
    parameter bit SKIP_DIS = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tdm_slot_mux_if.slave     bus
);
    localparam int CH_W  = (NUM_CH  > 2) ? $clog2(NUM_CH)  : 1;
    localparam int SYM_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;

    logic [CH_W-1:0]    chan_q,        chan_d;
    logic [CNT_W-1:0]   count_q,       count_d;
    logic [SYM_W-1:0]   sym_q,         sym_d;
    logic [DATA_W-1:0]  data_q,        data_d;
    logic               valid_q,       valid_d;
    logic               slot_start_q,  slot_start_d;
    logic               frame_start_q, frame_start_d;

    logic [CNT_W-1:0]   cur_len;
    logic [DATA_W-1:0]  cur_data;
    logic               cur_en;
    logic               tc;
    logic [CH_W-1:0]    chan_nxt;

    always_comb begin
        cur_len  = bus.slot_len[int'(chan_q)*CNT_W +: CNT_W];
        cur_data = bus.ch_data[int'(chan_q)*DATA_W +: DATA_W];
        cur_en   = bus.ch_en[chan_q];
        // >= so that shrinking slot_len below the running count ends the slot at once
        tc       = (count_q >= cur_len);
    end

    // Skip search walks c+1 .. c+NUM_CH (wrapping back to c); with nothing enabled
    // the plain successor stays in place so the schedule keeps rotating.
    always_comb begin
        int  c;
        logic found;
        c        = (int'(chan_q) + 1 >= NUM_CH) ? 0 : int'(chan_q) + 1;
        chan_nxt = CH_W'(c);
        found    = 1'b0;
        if (SKIP_DIS) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = int'(chan_q) + k;
                if (c >= NUM_CH) c = c - NUM_CH;
                if (!found && bus.ch_en[c]) begin
                    chan_nxt = CH_W'(c);
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        chan_d        = chan_q;
        count_d       = count_q;
        sym_d         = sym_q;
        data_d        = '0;
        valid_d       = 1'b0;
        slot_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (bus.run) begin
            data_d  = cur_en ? cur_data : '0;
            valid_d = cur_en;
            sym_d   = (sym_q == SYM_W'(SYM_DIV - 1)) ? '0 : sym_q + 1'b1;
            if (tc) begin
                count_d       = '0;
                chan_d        = chan_nxt;
                slot_start_d  = 1'b1;
                frame_start_d = (chan_nxt == '0);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chan_q        <= '0;
            count_q       <= '0;
            sym_q         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            slot_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            chan_q        <= chan_d;
            count_q       <= count_d;
            sym_q         <= sym_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            slot_start_q  <= slot_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.chan        = chan_q;
    assign bus.count       = count_q;
    assign bus.sym_cnt     = sym_q;
    assign bus.slot_start  = slot_start_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_tdm_slot_mux.sv
// tb/tb_tdm_slot_mux.sv - scoreboard bench for tdm_slot_mux, no-skip and skip variants side by side
module tb_tdm_slot_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  ch_en = 4'hF;
    logic [31:0] slot_len = {8'd43, 8'd76, 8'd109, 8'd142};
    logic [31:0] ch_data  = 32'hD3C2B1A0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tdm_slot_mux_if #(.NUM_CH(4), .DATA_W(8), .CNT_W(8), .SYM_DIV(13)) bus0 ();
    tdm_slot_mux_if #(.NUM_CH(4), .DATA_W(8), .CNT_W(8), .SYM_DIV(13)) bus1 ();

    assign bus0.run = run;   assign bus1.run = run;
    assign bus0.ch_en = ch_en;   assign bus1.ch_en = ch_en;
    assign bus0.slot_len = slot_len; assign bus1.slot_len = slot_len;
    assign bus0.ch_data = ch_data;  assign bus1.ch_data = ch_data;

    tdm_slot_mux #(.NUM_CH(4), .DATA_W(8), .CNT_W(8), .SYM_DIV(13), .SKIP_DIS(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0));
    tdm_slot_mux #(.NUM_CH(4), .DATA_W(8), .CNT_W(8), .SYM_DIV(13), .SKIP_DIS(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1));

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int chan; int cnt; int sym; int data; int valid; int ss; int fs;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t m_out[2];
    int   m_chan[2] = '{0, 0};
    int   m_cnt[2]  = '{0, 0};
    int   m_sym[2]  = '{0, 0};

    // reference model: pushes what each DUT must show after this edge
    always @(posedge clk) begin
        int len, nx;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_chan[d] = 0; m_cnt[d] = 0; m_sym[d] = 0;
                m_out[d] = '{default: 0};
            end else if (!run) begin
                m_out[d].data = 0; m_out[d].valid = 0; m_out[d].ss = 0; m_out[d].fs = 0;
            end else begin
                len = int'(slot_len[m_chan[d]*8 +: 8]);
                m_out[d].valid = int'(ch_en[m_chan[d]]);
                m_out[d].data  = ch_en[m_chan[d]] ? int'(ch_data[m_chan[d]*8 +: 8]) : 0;
                m_sym[d] = (m_sym[d] == 12) ? 0 : m_sym[d] + 1;
                if (m_cnt[d] >= len) begin
                    nx = (m_chan[d] + 1) % 4;
                    if (d == 1 && ch_en != 4'h0)
                        for (int k = 4; k >= 1; k--)
                            if (ch_en[(m_chan[d] + k) % 4]) nx = (m_chan[d] + k) % 4;
                    m_cnt[d] = 0; m_chan[d] = nx;
                    m_out[d].ss = 1; m_out[d].fs = (nx == 0) ? 1 : 0;
                end else begin
                    m_cnt[d] = m_cnt[d] + 1;
                    m_out[d].ss = 0; m_out[d].fs = 0;
                end
            end
            m_out[d].chan = m_chan[d]; m_out[d].cnt = m_cnt[d]; m_out[d].sym = m_sym[d];
        end
        sb0.push_back(m_out[0]);
        sb1.push_back(m_out[1]);
    end

    task automatic cmp_rec(input string who, input exp_t o, input exp_t e);
        chk({who, ".chan"},  o.chan,  e.chan);
        chk({who, ".count"}, o.cnt,   e.cnt);
        chk({who, ".sym"},   o.sym,   e.sym);
        chk({who, ".data"},  o.data,  e.data);
        chk({who, ".valid"}, o.valid, e.valid);
        chk({who, ".slot"},  o.ss,    e.ss);
        chk({who, ".frame"}, o.fs,    e.fs);
    endtask

    always @(negedge clk) begin
        exp_t o;
        if (sb0.size() > 0) begin
            o = '{int'(bus0.chan), int'(bus0.count), int'(bus0.sym_cnt), int'(bus0.data_out),
                  int'(bus0.data_valid), int'(bus0.slot_start), int'(bus0.frame_start)};
            cmp_rec("sb0", o, sb0.pop_front());
        end
        if (sb1.size() > 0) begin
            o = '{int'(bus1.chan), int'(bus1.count), int'(bus1.sym_cnt), int'(bus1.data_out),
                  int'(bus1.data_valid), int'(bus1.slot_start), int'(bus1.frame_start)};
            cmp_rec("sb1", o, sb1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // sel: 0 u0 slot, 1 u0 frame, 2 u1 slot, 3 u1 frame
    task automatic wait_pulse(input int sel, output int n);
        logic p;
        n = 0;
        do begin
            tick();
            n++;
            case (sel)
                0:       p = bus0.slot_start;
                1:       p = bus0.frame_start;
                2:       p = bus1.slot_start;
                default: p = bus1.frame_start;
            endcase
        end while (!p && n < 2000);
        if (n >= 2000) chk("pulse_timeout", n, -1);
    endtask

    task automatic wait_st(input int ch, input int cnt);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(int'(bus0.chan) == ch && int'(bus0.count) == cnt) && n < 2000);
        chk("reach_state", int'(n < 2000), 1);
    endtask

    initial begin
        int n, tot;
        int slot_exp[4] = '{143, 110, 77, 44};
        int seq_exp[3]  = '{2, 3, 0};
        int len_exp[3]  = '{143, 77, 44};

        rst = 1'b1; run = 1'b0;
        repeat (3) tick();
        chk("rst_chan", int'(bus0.chan), 0);
        chk("rst_count", int'(bus0.count), 0);
        chk("rst_valid", int'(bus0.data_valid), 0);

        // sym_cnt wraps at 13; data lags chan by one cycle
        rst = 1'b0; run = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            chk("sym_seq", int'(bus0.sym_cnt), i % 13);
            chk("no_early_strobe", int'(bus0.slot_start), 0);
            if (i == 1) chk("data_lag", int'(bus0.data_out), 8'hA0);
        end

        // per-channel slot lengths and frame period
        wait_pulse(1, n);
        chk("frame0_chan", int'(bus0.chan), 0);
        for (int c = 0; c < 4; c++) begin
            wait_pulse(0, n);
            chk("slot_cycles", n, slot_exp[c]);
            if (c == 0) begin
                chk("edge_chan", int'(bus0.chan), 1);
                chk("edge_data", int'(bus0.data_out), 8'hA0);
            end
        end
        chk("frame_at_ch3_end", int'(bus0.frame_start), 1);
        wait_pulse(1, n);
        chk("frame_period", n, 374);
        tick();
        chk("slot_edge_next_data", int'(bus0.data_out), 8'hA0);

        // disabled ch1 keeps its slot in no-skip mode
        ch_en = 4'b1101;
        do_reset();
        wait_st(1, 60);
        chk("dis_valid", int'(bus0.data_valid), 0);
        chk("dis_data", int'(bus0.data_out), 0);
        wait_pulse(1, n);
        wait_pulse(1, n);
        chk("noskip_frame", n, 374);

        // skip mode drops ch1
        do_reset();
        wait_pulse(3, n);
        chk("skip_first_frame", n, 264);
        tot = 0;
        for (int i = 0; i < 3; i++) begin
            wait_pulse(2, n);
            tot += n;
            chk("skip_seq", int'(bus1.chan), seq_exp[i]);
            chk("skip_len", n, len_exp[i]);
        end
        chk("skip_frame", tot, 264);
        chk("skip_frame_pulse", int'(bus1.frame_start), 1);

        // pause holds position
        ch_en = 4'hF;
        do_reset();
        wait_st(1, 50);
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pause_count", int'(bus0.count), 50);
            chk("pause_sym", int'(bus0.sym_cnt), 11);
            chk("pause_valid", int'(bus0.data_valid), 0);
        end
        run = 1'b1;
        tick();
        chk("resume_count", int'(bus0.count), 51);
        chk("resume_sym", int'(bus0.sym_cnt), 12);

        // reset mid-slot, with run still high
        wait_st(2, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_chan", int'(bus0.chan), 0);
        chk("mid_rst_count", int'(bus0.count), 0);
        chk("mid_rst_sym", int'(bus0.sym_cnt), 0);
        chk("mid_rst_data", int'(bus0.data_out), 0);
        chk("mid_rst_slot", int'(bus0.slot_start), 0);
        chk("mid_rst_frame", int'(bus0.frame_start), 0);

        // live slot_len shrink below count
        do_reset();
        wait_st(0, 100);
        slot_len[7:0] = 8'd20;
        tick();
        chk("shrink_count", int'(bus0.count), 0);
        chk("shrink_chan", int'(bus0.chan), 1);
        chk("shrink_slot", int'(bus0.slot_start), 1);

        // skip mode with nothing enabled still rotates
        slot_len = {8'd2, 8'd2, 8'd2, 8'd2};
        ch_en = 4'h0;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            wait_pulse(2, n);
            chk("none_rot", int'(bus1.chan), i % 4);
            chk("none_len", n, 3);
        end

        // skip mode, only ch2 enabled: back-to-back slots on ch2
        ch_en = 4'b0100;
        do_reset();
        wait_pulse(2, n);
        chk("single_first", int'(bus1.chan), 2);
        wait_pulse(2, n);
        chk("single_again", int'(bus1.chan), 2);
        chk("single_len", n, 3);

        // random phase, scoreboard only; includes slot_len=0 and pauses
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ch_data = $urandom;
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) slot_len = $urandom & 32'h03030303;
            tick();
        end
        run = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
